// File: rtl/resp_framer_if.sv
// Handshake bundle for resp_framer: upstream response (opcode/payload/count) and downstream byte stream.
// The slave view is the framer; the master view is whatever sits on both sides of it.
interface resp_framer_if;
  logic [7:0]  opcode_i;
  logic [63:0] data_i;
  logic [3:0]  nbytes_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;

  modport slave (
    input  opcode_i, data_i, nbytes_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );

  modport master (
    output opcode_i, data_i, nbytes_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );
endinterface

// File: rtl/resp_framer.sv
// Frames one response as opcode, RESV_P, len LSB, len MSB, payload LSB-first; first byte one cycle after accept.
// Fully registered outputs; the current byte holds while ready_i is low, one bubble cycle between packets.
module resp_framer #(
  parameter logic [7:0] RESV_P = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  resp_framer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;

  logic [1:0]  r_state;
  logic [2:0]  r_idx;
  logic [3:0]  r_n;
  logic [15:0] r_len;
  logic [63:0] r_pay;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ready;

  logic [3:0]  w_n;
  logic        w_xfer;
  logic        w_accept;
  logic        w_pay_last;

  assign w_n        = (bus.nbytes_i > 4'd8) ? 4'd8 : bus.nbytes_i;
  assign w_xfer     = r_valid && bus.ready_i;
  assign w_accept   = bus.valid_i && r_ready;
  assign w_pay_last = ({1'b0, r_idx} == (r_n - 4'd1));

  assign bus.ready_o = r_ready;
  assign bus.data_o  = r_data;
  assign bus.valid_o = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
      r_n     <= 4'd0;
      r_len   <= 16'd0;
      r_pay   <= 64'd0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_n     <= w_n;
            r_len   <= 16'd4 + {12'd0, w_n};
            r_pay   <= bus.data_i;
            r_data  <= bus.opcode_i;
            r_valid <= 1'b1;
            r_ready <= 1'b0;
            r_idx   <= 3'd0;
            r_state <= ST_HDR;
          end else begin
            r_ready <= 1'b1;
          end
        end

        ST_HDR: begin
          if (w_xfer) begin
            case (r_idx)
              3'd0: begin
                r_data <= RESV_P;
                r_idx  <= 3'd1;
              end
              3'd1: begin
                r_data <= r_len[7:0];
                r_idx  <= 3'd2;
              end
              3'd2: begin
                r_data <= r_len[15:8];
                r_idx  <= 3'd3;
              end
              default: begin
                r_idx <= 3'd0;
                if (r_n == 4'd0) begin
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
                end else begin
                  // Payload byte k is always the low byte of r_pay once k bytes have been shifted out.
                  r_data  <= r_pay[7:0];
                  r_pay   <= {8'h00, r_pay[63:8]};
                  r_state <= ST_PAY;
                end
              end
            endcase
          end
        end

        ST_PAY: begin
          if (w_xfer) begin
            if (w_pay_last) begin
              r_valid <= 1'b0;
              r_ready <= 1'b1;
              r_idx   <= 3'd0;
              r_state <= ST_IDLE;
            end else begin
              r_data <= r_pay[7:0];
              r_pay  <= {8'h00, r_pay[63:8]};
              r_idx  <= r_idx + 3'd1;
            end
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b0;
          r_idx   <= 3'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resp_framer.sv
// Randomized bench for resp_framer: a byte-queue model of each framed response plus handshake invariant checks.
module tb_resp_framer;
  localparam logic [7:0] RESV = 8'h00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  resp_framer_if bus();

  resp_framer #(.RESV_P(RESV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  bit         last_q[$];
  int         n_xfer   = 0;
  int         rmode    = 0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_dat  = 8'h00;
  bit         chk_idle  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected byte stream of one response, built straight from the framing rules.
  task automatic model_push(input logic [7:0] op, input logic [63:0] d, input logic [3:0] nb);
    int         n;
    int         len;
    logic [7:0] b[$];
    n   = (nb > 4'd8) ? 8 : int'(nb);
    len = 4 + n;
    b.push_back(op);
    b.push_back(RESV);
    b.push_back(len[7:0]);
    b.push_back(len[15:8]);
    for (int k = 0; k < n; k++) b.push_back(d[8*k +: 8]);
    for (int i = 0; i < b.size(); i++) begin
      exp_q.push_back(b[i]);
      last_q.push_back(i == b.size() - 1);
    end
  endtask

  initial begin
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       bus.ready_i = 1'b1;
        1:       bus.ready_i = ~bus.ready_i;
        default: bus.ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
        chk_idle  = 1'b0;
      end else begin
        if (chk_idle) begin
          check_eq("idle_rdy", bus.ready_o, 1);
          check_eq("idle_vld", bus.valid_o, 0);
          chk_idle = 1'b0;
        end
        if (prev_hold) begin
          check_eq("hold_vld", bus.valid_o, 1);
          check_eq("hold_dat", bus.data_o, prev_dat);
        end
        if (bus.valid_o) check_eq("busy_rdy", bus.ready_o, 0);
        if (bus.valid_o && bus.ready_i) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_byte", bus.data_o, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            check_eq("byte", bus.data_o, exp_q.pop_front());
            if (last_q.pop_front()) chk_idle = 1'b1;
          end
          n_xfer++;
        end
        prev_hold = bus.valid_o && !bus.ready_i;
        prev_dat  = bus.data_o;
      end
    end
  end

  task automatic send(input logic [7:0] op, input logic [63:0] d, input logic [3:0] nb);
    bit got;
    got = 1'b0;
    bus.opcode_i = op;
    bus.data_i   = d;
    bus.nbytes_i = nb;
    bus.valid_i  = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        model_push(op, d, nb);
        got = 1'b1;
      end
    end
    check_eq("accept", got, 1);
    @(posedge clk);
    #1;
    bus.valid_i  = 1'b0;
    bus.opcode_i = 8'($urandom);
    bus.data_i   = {$urandom, $urandom};
    bus.nbytes_i = 4'($urandom);
    @(negedge clk);
    check_eq("first_vld", bus.valid_o, 1);
    check_eq("first_dat", bus.data_o, op);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !bus.valid_o) done = 1'b1;
    end
    check_eq("drain", done, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int base;
    bit hit;
    rst          = 1'b1;
    bus.valid_i  = 1'b0;
    bus.opcode_i = 8'h00;
    bus.data_i   = 64'd0;
    bus.nbytes_i = 4'd0;
    #1;
    check_eq("rst_rdy", bus.ready_o, 0);
    check_eq("rst_vld", bus.valid_o, 0);
    check_eq("rst_dat", bus.data_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rdy_pre_edge", bus.ready_o, 0);
    @(posedge clk);
    #1;
    check_eq("rdy_post_rst", bus.ready_o, 1);

    rmode = 0;
    send(8'hA5, 64'h0000_0000_DEAD_BEEF, 4'd4);
    drain();

    rmode = 1;
    send(8'hA5, 64'h0000_0000_DEAD_BEEF, 4'd4);
    drain();

    rmode = 0;
    send(8'h3C, 64'h1122_3344_5566_7788, 4'd0);
    drain();

    send(8'h77, 64'h0807_0605_0403_0201, 4'd12);
    drain();

    // Reset lands mid-packet, after the fifth byte has transferred.
    base = n_xfer;
    send(8'hA5, 64'h0000_0000_DEAD_BEEF, 4'd4);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (n_xfer - base >= 5) hit = 1'b1;
    end
    check_eq("five_bytes", hit, 1);
    rst = 1'b1;
    #1;
    check_eq("arst_vld", bus.valid_o, 0);
    check_eq("arst_rdy", bus.ready_o, 0);
    exp_q.delete();
    last_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rdy_after_arst", bus.ready_o, 1);
    send(8'hA5, 64'h0000_0000_DEAD_BEEF, 4'd4);
    drain();

    base = n_xfer;
    send(8'h21, {$urandom, $urandom}, 4'd1);
    send(8'h22, {$urandom, $urandom}, 4'd1);
    drain();
    check_eq("b2b_count", 64'(n_xfer - base), 10);

    for (int p = 0; p < 30; p++) begin
      rmode = $urandom_range(0, 2);
      send(8'($urandom), {$urandom, $urandom}, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    check_eq("model_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
